// File: rtl/lab5_meter_pkg.sv
// Shared types and defaults for the lab5 period meter.
package lab5_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_e;

    localparam int CNT_W_DEF  = 8;
    localparam int LOCK_N_DEF = 4;

    // All-ones value of the given width (width must be 1..32).
    function automatic logic [31:0] sat_max(input int width);
        return 32'hFFFF_FFFF >> (32 - width);
    endfunction

endpackage

// File: rtl/lab5_sync_edge.sv
// Two-flop synchronizer plus edge detector for the measured signal.
// With LAB5_PERIOD_METER_FULL_PERIOD_EN defined only rising edges are reported.
module lab5_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic edge_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    // NOTE: prev_q resets to 0, so a signal already high at release yields one
    // edge; the meter treats that as its arming edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= sig_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

`ifdef LAB5_PERIOD_METER_FULL_PERIOD_EN
    assign edge_o = s2_q & ~prev_q;
`else
    assign edge_o = s2_q ^ prev_q;
`endif

endmodule

// File: rtl/lab5_period_meter.sv
// Counts clk cycles between successive edges of a slow asynchronous square wave
// and flags lock after LOCK_N equal measurements. Option: LAB5_PERIOD_METER_FULL_PERIOD_EN.
module lab5_period_meter
    import lab5_meter_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int LOCK_N = LOCK_N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(sat_max(CNT_W));
    localparam logic [3:0]       MATCH_TOP = 4'(LOCK_N - 1);

    logic sig_edge;

    state_e           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             sat_q,        sat_d;
    logic [CNT_W-1:0] meas_cnt_q,   meas_cnt_d;
    logic             meas_valid_q, meas_valid_d;
    logic             overflow_q,   overflow_d;
    logic             locked_q,     locked_d;
    logic [3:0]       match_q,      match_d;
    logic [CNT_W-1:0] new_cnt;

    lab5_sync_edge u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (sig_in),
        .edge_o (sig_edge)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sat_d        = sat_q;
        meas_cnt_d   = meas_cnt_q;
        meas_valid_d = 1'b0;
        overflow_d   = overflow_q;
        locked_d     = locked_q;
        match_d      = match_q;
        new_cnt      = sat_q ? CNT_MAX : cnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (sig_edge) begin
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    state_d = MEAS;
                end
            end
            MEAS: begin
                if (sig_edge) begin
                    meas_cnt_d   = new_cnt;
                    overflow_d   = sat_q;
                    meas_valid_d = 1'b1;
                    cnt_d        = '0;
                    sat_d        = 1'b0;
                    // Compare against the previous report before it is overwritten.
                    if (sat_q || (new_cnt != meas_cnt_q)) begin
                        match_d  = '0;
                        locked_d = 1'b0;
                    end else begin
                        match_d  = (match_q == MATCH_TOP) ? match_q : match_q + 4'd1;
                        locked_d = (match_d == MATCH_TOP);
                    end
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    sat_d = (cnt_d == CNT_MAX);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            meas_cnt_q   <= '0;
            meas_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            locked_q     <= 1'b0;
            match_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sat_q        <= sat_d;
            meas_cnt_q   <= meas_cnt_d;
            meas_valid_q <= meas_valid_d;
            overflow_q   <= overflow_d;
            locked_q     <= locked_d;
            match_q      <= match_d;
        end
    end

    assign meas_cnt   = meas_cnt_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_lab5_period_meter.sv
// Scoreboard bench for lab5_period_meter: a cycle-sampling reference model queues
// expected reports, a negedge monitor compares them against the DUT.
module tb_lab5_period_meter;

    localparam int CNT_W  = 8;
    localparam int LOCK_N = 4;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             sig_in;
    logic [CNT_W-1:0] meas_cnt;
    logic             meas_valid;
    logic             locked;
    logic             overflow;

    lab5_period_meter #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .meas_cnt   (meas_cnt),
        .meas_valid (meas_valid),
        .locked     (locked),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic             ovf;
        logic             lck;
        int               due;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: samples sig_in once per clock, measures sample distance between
    // counted edges, and derives lock from the history of the last LOCK_N reports.
    bit   prev_lvl;
    bit   armed;
    bit   lvl;
    bit   is_edge;
    int   cyc;
    int   last_cyc;
    int   n;
    int   hist[$];
    exp_t e;

    initial begin
        prev_lvl = 1'b0;
        armed    = 1'b0;
        cyc      = 0;
        last_cyc = 0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                prev_lvl = 1'b0;
                armed    = 1'b0;
                cyc      = 0;
                hist.delete();
                exp_q.delete();
            end else begin
                cyc++;
                lvl = sig_in;
`ifdef LAB5_PERIOD_METER_FULL_PERIOD_EN
                is_edge = lvl && !prev_lvl;
`else
                is_edge = (lvl != prev_lvl);
`endif
                prev_lvl = lvl;
                if (is_edge) begin
                    if (armed) begin
                        n     = cyc - last_cyc;
                        e.ovf = (n > MAXV);
                        e.cnt = e.ovf ? CNT_W'(MAXV) : CNT_W'(n);
                        hist.push_back(e.ovf ? -1 : n);
                        if (hist.size() > LOCK_N) void'(hist.pop_front());
                        e.lck = (hist.size() == LOCK_N);
                        foreach (hist[i]) if (hist[i] < 0 || hist[i] != hist[0]) e.lck = 1'b0;
                        e.due = cyc + 2;
                        exp_q.push_back(e);
                    end
                    armed    = 1'b1;
                    last_cyc = cyc;
                end
            end
        end
    end

    // Monitor: strobes must match queued reports at the expected cycle; outputs hold otherwise.
    exp_t hold;
    exp_t got;

    initial begin
        hold = '{cnt: '0, ovf: 1'b0, lck: 1'b0, due: 0};
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold = '{cnt: '0, ovf: 1'b0, lck: 1'b0, due: 0};
                check("reset_outputs", {meas_valid, locked, overflow, meas_cnt}, '0);
            end else if (meas_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", meas_valid, 1'b0);
                end else begin
                    got = exp_q.pop_front();
                    check("strobe_cycle", cyc, got.due);
                    check("meas_cnt", meas_cnt, got.cnt);
                    check("overflow", overflow, got.ovf);
                    check("locked", locked, got.lck);
                    hold = got;
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    check("missed_strobe", meas_valid, 1'b1);
                    void'(exp_q.pop_front());
                end
                check("hold_outputs", {locked, overflow, meas_cnt}, {hold.lck, hold.ovf, hold.cnt});
            end
        end
    end

    task automatic run(input int half, input int edges);
        repeat (edges) begin
            repeat (half) @(negedge clk);
            sig_in = ~sig_in;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset", {meas_valid, locked, overflow, meas_cnt}, '0);
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        rst    = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("reset_state", {meas_valid, locked, overflow, meas_cnt}, '0);
        rst = 1'b1;

        run(10, 8);
        run(7, 6);
        run(300, 1);
        run(10, 3);

        if (sig_in) run(10, 1);
        run(10, 2);
        repeat (5) @(negedge clk);
        pulse_reset();
        run(10, 4);

        run(1, 10);
        run(12, 5);

        for (int seg = 0; seg < 40; seg++) begin
            int half;
            half = ($urandom_range(0, 9) == 0) ? 260 + $urandom_range(0, 80)
                                               : $urandom_range(1, 40);
            run(half, $urandom_range(1, 6));
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                pulse_reset();
            end
        end

        repeat (8) @(negedge clk);
        #1 check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
